vga_timing_gen: RTL

Pixel-timing source for the VGA display path. It divides the system clock down to the pixel rate and runs the horizontal and vertical scan counters. It publishes the current pixel coordinate (x, y) to the combinational frame renderer, which returns r/g/b for that coordinate. It then re-registers that colour, blanked where required, together with hsync/vsync/blank so that everything reaches the DAC aligned.

---
 rtl/vga_timing_gen.sv | 133 +++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// VGA pixel-timing generator: clock divider, h/v scan counters and an output stage
// that re-registers renderer colour with sync and blanking so everything leaves aligned.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned CLK_DIV  = 2
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] r_in_i,
    input  logic [7:0] g_in_i,
    input  logic [7:0] b_in_i,
    output logic [9:0] x_o,
    output logic [9:0] y_o,
    output logic       pix_en_o,
    output logic       vga_clk_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       sync_b_o,
    output logic       blank_b_o,
    output logic [7:0] vga_r_o,
    output logic [7:0] vga_g_o,
    output logic [7:0] vga_b_o,
    output logic       frame_start_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DivW    = $clog2(CLK_DIV);

    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
    localparam logic [DivW-1:0] DivHalf = DivW'(CLK_DIV / 2);

    localparam logic [9:0] HLast      = 10'(H_TOTAL - 1);
    localparam logic [9:0] VLast      = 10'(V_TOTAL - 1);
    localparam logic [9:0] HActive    = 10'(H_ACTIVE);
    localparam logic [9:0] VActive    = 10'(V_ACTIVE);
    localparam logic [9:0] HSyncStart = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HSyncEnd   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VSyncStart = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VSyncEnd   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DivW-1:0] div_q, div_d;
    logic [9:0]      hcnt_q, hcnt_d;
    logic [9:0]      vcnt_q, vcnt_d;
    logic            vga_clk_q;
    logic            hsync_q, hsync_d;
    logic            vsync_q, vsync_d;
    logic            blank_b_q, blank_b_d;
    logic [7:0]      r_q, g_q, b_q;
    logic [7:0]      r_d, g_d, b_d;
    logic            frame_start_q, frame_start_d;
    logic            pix_en;

    // Divider, scan-counter advance and stage-2 next-state decode
    always_comb begin
        pix_en = (div_q == DivLast);
        div_d  = pix_en ? '0 : div_q + 1'b1;

        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (pix_en) begin
            if (hcnt_q == HLast) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == VLast) ? '0 : vcnt_q + 1'b1;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
        end

        hsync_d   = !((hcnt_q >= HSyncStart) && (hcnt_q < HSyncEnd));
        vsync_d   = !((vcnt_q >= VSyncStart) && (vcnt_q < VSyncEnd));
        blank_b_d = (hcnt_q < HActive) && (vcnt_q < VActive);
        r_d       = blank_b_d ? r_in_i : 8'h00;
        g_d       = blank_b_d ? g_in_i : 8'h00;
        b_d       = blank_b_d ? b_in_i : 8'h00;

        // Pulse lands in the clk right after the (last, last) -> (0, 0) step
        frame_start_d = pix_en && (hcnt_q == HLast) && (vcnt_q == VLast);
    end

    // State registers; stage-2 only loads on the pixel strobe
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            div_q         <= '0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            vga_clk_q     <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            blank_b_q     <= 1'b0;
            r_q           <= '0;
            g_q           <= '0;
            b_q           <= '0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            // Registered from next div so it tracks the current div value exactly
            vga_clk_q     <= (div_d >= DivHalf);
            frame_start_q <= frame_start_d;
            if (pix_en) begin
                hsync_q   <= hsync_d;
                vsync_q   <= vsync_d;
                blank_b_q <= blank_b_d;
                r_q       <= r_d;
                g_q       <= g_d;
                b_q       <= b_d;
            end
        end
    end

    assign x_o           = hcnt_q;
    assign y_o           = vcnt_q;
    assign pix_en_o      = pix_en;
    assign vga_clk_o     = vga_clk_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign sync_b_o      = hsync_q & vsync_q;
    assign blank_b_o     = blank_b_q;
    assign vga_r_o       = r_q;
    assign vga_g_o       = g_q;
    assign vga_b_o       = b_q;
    assign frame_start_o = frame_start_q;

endmodule
